// File: rtl/ahb_slave_responder_pkg.sv
// Shared AHB slave definitions: bus field encodings, responder FSM states and
// the strobe / legality helpers used by the responder.
package ahb_defs;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slv_state_e;

  // Little-endian byte strobe for a legal (aligned) transfer.
  function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr_lsb);
    logic [3:0] m;
    case (hsize)
      HSIZE_BYTE: m = 4'b0001 << addr_lsb;
      HSIZE_HALF: m = addr_lsb[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic is_illegal(input logic [31:0] offset, input logic [2:0] hsize,
                                      input int unsigned mem_bytes);
    logic bad;
    bad = (offset >= mem_bytes) || (hsize > HSIZE_WORD);
    if ((hsize == HSIZE_HALF) && offset[0]) bad = 1'b1;
    if ((hsize == HSIZE_WORD) && (offset[1:0] != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Word-organised backing store: byte-strobed synchronous write, combinational read.
module ahb_slave_mem_array #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned IW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] addr_i,
  input  logic [3:0]    strb_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (strb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave_responder.sv
// AHB slave responder: byte-addressable memory region with programmable wait
// states and a two-cycle ERROR response for out-of-range or misaligned beats.
module ahb_slave_responder
  import ahb_defs::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam int unsigned IW    = (AW > 2) ? AW - 2 : 1;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $fatal(1, "ahb_slave_responder: DATA_WIDTH must be 32");
  end
  if ((MEM_BYTES < 4) || ((MEM_BYTES & (MEM_BYTES - 1)) != 0)) begin : g_bad_size
    $fatal(1, "ahb_slave_responder: MEM_BYTES must be a power of 2, at least 4");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait
    $fatal(1, "ahb_slave_responder: WAIT_STATES must be 0..15");
  end

  slv_state_e    state_q, state_d, cap_state;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic [31:0]   offset;
  logic          capture, cap_err;
  logic          read_beat, mem_we;
  logic [3:0]    mem_strb;
  logic [31:0]   mem_rdata;
  logic          unused_ok;

  assign unused_ok = ^{HBURST, HTRANS[0]};

  assign offset    = HADDR - BASE_ADDR;
  assign capture   = HSEL && HREADY && HTRANS[1];
  assign cap_err   = is_illegal(offset, HSIZE, MEM_BYTES);
  assign cap_state = cap_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);
  assign mem_strb  = lane_mask(size_q, addr_q[1:0]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      hrdata_q <= hrdata_d;
    end
  end

  // IDLE, DATA and ERR2 all drive HREADYOUT high, so each may accept the next
  // address phase; with HREADY low elsewhere on the bus they simply hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_STATES)) state_d = S_DATA;
        else                          cnt_d   = cnt_q + 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (HREADY) begin
          if (capture) begin
            state_d = cap_state;
            addr_d  = offset[AW-1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
            cnt_d   = 4'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    read_beat = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      S_WAIT: HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      S_ERR2: HRESP = HRESP_ERROR;
      S_DATA: begin
        read_beat = !write_q;
        mem_we    = write_q && HREADY;
      end
      default: ;
    endcase
    HRDATA = read_beat ? mem_rdata : hrdata_q;
  end

  assign hrdata_d = read_beat ? mem_rdata : hrdata_q;

  ahb_slave_mem_array #(
    .WORDS (WORDS),
    .IW    (IW)
  ) u_mem (
    .clk_i   (HCLK),
    .we_i    (mem_we),
    .addr_i  (IW'(addr_q >> 2)),
    .strb_i  (mem_strb),
    .wdata_i (HWDATA),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Bench for ahb_slave_responder: three regions on one bus, directed and random
// transfers checked against a byte-level memory and response-sequence model.
module tb_ahb_slave_responder;

  localparam logic [31:0] BASE0 = 32'h000, BASE1 = 32'h400, BASE2 = 32'h800;
  localparam int unsigned WS0 = 0, WS1 = 2, WS2 = 3;
  localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam int unsigned CYCLE_LIMIT = 5000;

  typedef struct {
    int unsigned slv;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] ex;
  } xfer_t;

  logic        HCLK, HRESETn;
  logic [2:0]  hsel;
  logic [31:0] haddr, hwdata;
  logic        hwrite, hready;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [2:0]  hreadyout;
  logic [1:0]  hresp  [3];
  logic [31:0] hrdata [3];

  int unsigned n_chk = 0, n_err = 0;
  logic [7:0]  mb [3][1024];
  xfer_t       tq[$];
  xfer_t       ap, dp;
  logic        ap_valid = 1'b0, dp_valid = 1'b0, dp_err = 1'b0;
  logic [1:0]  dp_slv = '0;
  logic [1:0]  dp_beats[$];

  assign hready = dp_valid ? hreadyout[dp_slv] : 1'b1;

  ahb_slave_responder #(.BASE_ADDR(BASE0), .MEM_BYTES(1024), .WAIT_STATES(WS0), .DATA_WIDTH(32)) u_s0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));
  ahb_slave_responder #(.BASE_ADDR(BASE1), .MEM_BYTES(1024), .WAIT_STATES(WS1), .DATA_WIDTH(32)) u_s1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));
  ahb_slave_responder #(.BASE_ADDR(BASE2), .MEM_BYTES(1024), .WAIT_STATES(WS2), .DATA_WIDTH(32)) u_s2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input int unsigned s);
    return (s == 0) ? BASE0 : (s == 1) ? BASE1 : BASE2;
  endfunction

  function automatic int unsigned ws_of(input int unsigned s);
    return (s == 0) ? WS0 : (s == 1) ? WS1 : WS2;
  endfunction

  function automatic bit illegal(input xfer_t t);
    logic [31:0] off;
    off = t.addr - base_of(t.slv);
    if (t.sz > 3'd2) return 1'b1;
    if (off >= 32'd1024) return 1'b1;
    return (t.addr % (32'd1 << t.sz)) != 32'd0;
  endfunction

  function automatic logic [31:0] model_word(input int unsigned s, input logic [31:0] off);
    logic [9:0] w;
    w = {off[9:2], 2'b00};
    return {mb[s][w + 10'd3], mb[s][w + 10'd2], mb[s][w + 10'd1], mb[s][w]};
  endfunction

  task automatic model_write(input xfer_t t);
    logic [31:0] a;
    for (int unsigned i = 0; i < (32'd1 << t.sz); i++) begin
      a = t.addr - base_of(t.slv) + i;
      mb[t.slv][a[9:0]] = t.wd[8*a[1:0] +: 8];
    end
  endtask

  function automatic xfer_t mk(input int unsigned s, input logic [31:0] a, input logic w,
                               input logic [1:0] tr, input logic [2:0] sz, input logic [31:0] wd,
                               input logic chk, input logic [31:0] ex);
    xfer_t t;
    t.slv = s; t.addr = a; t.wr = w; t.tr = tr; t.sz = sz; t.wd = wd; t.chk = chk; t.ex = ex;
    return t;
  endfunction

  task automatic wr(input int unsigned s, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    tq.push_back(mk(s, a, 1'b1, T_NSEQ, sz, d, 1'b0, '0));
  endtask

  task automatic rd(input int unsigned s, input logic [31:0] a, input logic [2:0] sz,
                    input logic chk, input logic [31:0] ex);
    tq.push_back(mk(s, a, 1'b0, T_NSEQ, sz, '0, chk, ex));
  endtask

  task automatic present_next();
    if (tq.size() > 0) begin
      ap       = tq.pop_front();
      ap_valid = 1'b1;
      hsel     = 3'(3'b001 << ap.slv);
      haddr    = ap.addr;
      hwrite   = ap.wr;
      htrans   = ap.tr;
      hsize    = ap.sz;
    end else begin
      ap_valid = 1'b0;
      hsel     = '0;
      haddr    = $urandom();
      hwrite   = 1'($urandom_range(0, 1));
      htrans   = T_IDLE;
      hsize    = 3'd2;
    end
    hburst = 3'($urandom_range(0, 7));
  endtask

  // Expected {HREADYOUT, HRESP[0]} for each cycle of the transfer's data phase.
  task automatic load_dp(input xfer_t t);
    dp     = t;
    dp_slv = 2'(t.slv);
    dp_err = t.tr[1] && illegal(t);
    dp_beats.delete();
    if (!t.tr[1]) begin
      dp_beats.push_back(2'b10);
    end else if (dp_err) begin
      dp_beats.push_back(2'b01);
      dp_beats.push_back(2'b11);
    end else begin
      for (int unsigned i = 0; i < ws_of(t.slv); i++) dp_beats.push_back(2'b00);
      dp_beats.push_back(2'b10);
    end
  endtask

  task automatic run_q();
    int unsigned cyc;
    logic        rdy;
    logic [1:0]  b;
    cyc = 0;
    present_next();
    while ((ap_valid || dp_valid || (tq.size() > 0)) && (cyc < CYCLE_LIMIT)) begin
      @(negedge HCLK);
      rdy = hready;
      if (dp_valid) begin
        if (dp_beats.size() > 0) b = dp_beats.pop_front();
        else                     b = {1'b1, dp_err};
        check_eq("hreadyout", {31'd0, hreadyout[dp_slv]}, {31'd0, b[1]});
        check_eq("hresp", {30'd0, hresp[dp_slv]}, {31'd0, b[0]});
        if (b[1] && !b[0] && !dp.wr && dp.tr[1])
          check_eq("hrdata", hrdata[dp_slv],
                   dp.chk ? dp.ex : model_word(dp.slv, dp.addr - base_of(dp.slv)));
      end
      @(posedge HCLK);
      #1;
      cyc++;
      if (rdy) begin
        if (dp_valid && !dp_err && dp.wr && dp.tr[1]) model_write(dp);
        dp_valid = ap_valid;
        if (ap_valid) load_dp(ap);
        hwdata = (dp_valid && dp.wr) ? dp.wd : $urandom();
        present_next();
      end
    end
    check_eq("drain", {29'd0, ap_valid, dp_valid, tq.size() != 0}, 32'd0);
  endtask

  initial begin
    logic [31:0] w30, off;
    int unsigned s, r;
    logic [2:0]  sz;

    HRESETn = 1'b0;
    hwdata  = '0;
    present_next();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    for (int unsigned k = 0; k < 3; k++) begin
      check_eq("reset_ready", {31'd0, hreadyout[k]}, 32'd1);
      check_eq("reset_resp", {30'd0, hresp[k]}, 32'd0);
      check_eq("reset_rdata", hrdata[k], 32'd0);
    end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    for (int unsigned k = 0; k < 3; k++)
      for (int unsigned w = 0; w < 16; w++)
        wr(k, base_of(k) + 4 * w, 3'd2, $urandom());

    wr(0, 32'h10, 3'd2, 32'hDEADBEEF);
    rd(0, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF);
    wr(0, 32'h10, 3'd2, 32'h11223344);
    wr(0, 32'h13, 3'd0, 32'hAB000000);
    rd(0, 32'h10, 3'd2, 1'b1, 32'hAB223344);
    wr(0, 32'h12, 3'd1, 32'hCAFE0000);
    rd(0, 32'h10, 3'd2, 1'b1, 32'hCAFE3344);
    wr(0, 32'h00, 3'd2, 32'h01020304);
    wr(0, 32'h02, 3'd2, 32'hFFFFFFFF);
    rd(0, 32'h00, 3'd2, 1'b1, 32'h01020304);
    rd(1, 32'h800, 3'd2, 1'b0, '0);
    rd(1, 32'h400, 3'd3, 1'b0, '0);
    rd(1, 32'h420, 3'd2, 1'b0, '0);
    rd(1, 32'h424, 3'd2, 1'b0, '0);
    run_q();

    // Reset in the second wait cycle of a write must drop the write.
    w30 = ~model_word(2, 32'h30);
    wr(2, 32'h830, 3'd2, w30);
    present_next();
    @(posedge HCLK);
    #1;
    hwdata = w30;
    present_next();
    @(negedge HCLK);
    check_eq("rst_wait1", {31'd0, hreadyout[2]}, 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    #1;
    for (int unsigned k = 0; k < 3; k++) begin
      check_eq("rst_abort_ready", {31'd0, hreadyout[k]}, 32'd1);
      check_eq("rst_abort_resp", {30'd0, hresp[k]}, 32'd0);
      check_eq("rst_abort_rdata", hrdata[k], 32'd0);
    end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    rd(2, 32'h830, 3'd2, 1'b0, '0);
    tq.push_back(mk(2, 32'h834, 1'b0, T_IDLE, 3'd2, '0, 1'b0, '0));
    run_q();

    for (int n = 0; n < 120; n++) begin
      s   = $urandom_range(0, 2);
      r   = $urandom_range(0, 9);
      sz  = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
      off = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if ((sz == 3'd1) && ($urandom_range(0, 4) != 0)) off[0] = 1'b0;
      if ((sz == 3'd2) && ($urandom_range(0, 4) != 0)) off[1:0] = 2'b00;
      r = $urandom_range(0, 15);
      if (r == 0)      off = off + 32'd1024;
      else if (r == 1) off = 32'hFFFFFFFC;
      r = $urandom_range(0, 7);
      tq.push_back(mk(s, base_of(s) + off, 1'($urandom_range(0, 1)),
                      (r == 0) ? T_IDLE : (r == 1) ? T_BUSY : (r < 5) ? T_NSEQ : T_SEQ,
                      sz, $urandom(), 1'b0, '0));
    end
    run_q();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
